mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 27 ++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage_lane_align.sv | 65 ++++++
 rtl/mem_access_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Contents: access-size encodings, stage FSM states, MEM/WB field widths.
// Imported by the lane aligner and the stage top.
package mem_access_stage_pkg;

    localparam int SIZE_W       = 2;
    localparam int MEM_TO_REG_W = 2;
    localparam int REG_WRITE_W  = 1;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } memSizeE;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stageStateE;

    // Number of bytes touched by an access of the given size.
    function automatic int sizeBytes(memSizeE size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Memory bus between the memory-access stage (master) and the data memory (slave).
// Request side: mem_req/mem_we/mem_addr/mem_wdata/mem_be; response side: mem_ack/mem_rdata.
// The master holds the request stable until mem_ack; mem_rdata is bus-aligned.
interface mem_access_stage_if #(
    parameter int XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane helper: byte enables, store replication, load extraction/extension, misalign detect.
// Purely combinational (zero latency), no state and no handshake.
// Ports: addrLow/size/isUnsigned select the lane; storeData/loadData in, byteEn/storeRep/loadExt/misaligned out.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        addrLow,
    input  memSizeE           size,
    input  logic              isUnsigned,
    input  logic [XLEN-1:0]   storeData,
    input  logic [XLEN-1:0]   loadData,
    output logic [XLEN/8-1:0] byteEn,
    output logic [XLEN-1:0]   storeRep,
    output logic [XLEN-1:0]   loadExt,
    output logic              misaligned
);
    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);

    logic [LANE_W-1:0] laneOfs;
    logic [NB-1:0]     sizeMask;
    logic [XLEN-1:0]   shifted;

    assign laneOfs  = addrLow[LANE_W-1:0];
    assign sizeMask = NB'((64'd1 << sizeBytes(size)) - 64'd1);
    assign byteEn   = sizeMask << laneOfs;
    // Bring the addressed lane down to bit 0 before extension.
    assign shifted  = loadData >> {laneOfs, 3'b000};

    always_comb begin
        storeRep   = storeData;
        loadExt    = shifted;
        misaligned = 1'b0;
        unique case (size)
            SIZE_BYTE: begin
                storeRep = {NB{storeData[7:0]}};
                loadExt  = isUnsigned ? XLEN'(shifted[7:0]) : XLEN'($signed(shifted[7:0]));
            end
            SIZE_HALF: begin
                storeRep   = {(NB/2){storeData[15:0]}};
                loadExt    = isUnsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
                misaligned = addrLow[0];
            end
            SIZE_WORD: begin
                storeRep   = {(XLEN/32){storeData[31:0]}};
                loadExt    = isUnsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
                misaligned = |addrLow[1:0];
            end
            SIZE_DWORD: begin
                storeRep   = storeData;
                loadExt    = shifted;
                // A doubleword does not exist on a 32-bit bus, so it is reported as misaligned.
                misaligned = (XLEN != 64) || (|addrLow);
            end
            default: begin
                storeRep   = storeData;
                loadExt    = shifted;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on the memory bus and fills the MEM/WB register.
// Latency: pass-through/misaligned 1 cycle; memory op 1 + ack-wait cycles + 1; bus timeout after TIMEOUT request cycles.
// Backpressure: in_ready is high only in IDLE, so one op is in flight at a time.
// Ports: clk/rst; upstream in_* with in_valid/in_ready and flush; mem bus interface (master); wb_* MEM/WB outputs; misalign/bus_err pulses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mem_read,
    input  logic                    in_mem_write,
    input  logic [SIZE_W-1:0]       in_size,
    input  logic                    in_unsigned,
    input  logic [XLEN-1:0]         in_alu_result,
    input  logic [XLEN-1:0]         in_write_data,
    input  logic [XLEN-1:0]         in_pc_plus4,
    input  logic [MEM_TO_REG_W-1:0] in_mem_to_reg,
    input  logic                    in_reg_write,
    input  logic [RA_W-1:0]         in_write_reg,
    input  logic                    flush,

    mem_access_stage_if.master      mem,

    output logic                    wb_valid,
    output logic [XLEN-1:0]         wb_alu_result,
    output logic [XLEN-1:0]         wb_read_data,
    output logic [XLEN-1:0]         wb_pc_plus4,
    output logic [RA_W-1:0]         wb_write_reg,
    output logic [MEM_TO_REG_W-1:0] wb_mem_to_reg,
    output logic                    wb_reg_write,
    output logic                    misalign,
    output logic                    bus_err
);
    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    // The counter starts at 0 on the first request cycle, so TIMEOUT-1 marks the last allowed one.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    stageStateE state, stateNext;

    // Bus request registers
    logic            memReq, memWe;
    logic [XLEN-1:0] memAddr, memWdata;
    logic [NB-1:0]   memBe;

    // Op captured at issue, used when the bus completes
    logic [XLEN-1:0]         capAlu, capPc;
    logic [RA_W-1:0]         capWriteReg;
    logic [MEM_TO_REG_W-1:0] capMemToReg;
    logic                    capRegWrite, capRead, capUnsigned;
    memSizeE                 capSize;

    logic [CNT_W-1:0] tmoCnt;
    logic             flushPend;

    // FSM strobes
    logic passFire, misFire, startReq, ackDone, tmoDone, suppress;

    // Lane aligner: looks at the incoming op in IDLE, at the captured op while in REQ.
    logic [2:0]      alignAddrLow;
    memSizeE         alignSize;
    logic            alignUns;
    logic [NB-1:0]   laneBe;
    logic [XLEN-1:0] laneWdata, laneLoad;
    logic            laneMis;

    assign alignAddrLow = (state == IDLE) ? in_alu_result[2:0] : capAlu[2:0];
    assign alignSize    = (state == IDLE) ? memSizeE'(in_size) : capSize;
    assign alignUns     = (state == IDLE) ? in_unsigned : capUnsigned;

    mem_lane_align #(.XLEN(XLEN)) uLaneAlign (
        .addrLow    (alignAddrLow),
        .size       (alignSize),
        .isUnsigned (alignUns),
        .storeData  (in_write_data),
        .loadData   (mem.mem_rdata),
        .byteEn     (laneBe),
        .storeRep   (laneWdata),
        .loadExt    (laneLoad),
        .misaligned (laneMis)
    );

    assign mem.mem_req   = memReq;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = memWdata;
    assign mem.mem_be    = memBe;

    // A flush seen at any point of the bus transaction hides its writeback.
    assign suppress = flushPend | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        passFire  = 1'b0;
        misFire   = 1'b0;
        startReq  = 1'b0;
        ackDone   = 1'b0;
        tmoDone   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    if (!(in_mem_read || in_mem_write)) begin
                        passFire = 1'b1;
                    end else if (laneMis) begin
                        misFire = 1'b1;
                    end else begin
                        startReq  = 1'b1;
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (mem.mem_ack) begin
                    ackDone   = 1'b1;
                    stateNext = IDLE;
                end else if (tmoCnt == TMO_LAST) begin
                    tmoDone   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memReq        <= 1'b0;
            memWe         <= 1'b0;
            memAddr       <= '0;
            memWdata      <= '0;
            memBe         <= '0;
            capAlu        <= '0;
            capPc         <= '0;
            capWriteReg   <= '0;
            capMemToReg   <= '0;
            capRegWrite   <= 1'b0;
            capRead       <= 1'b0;
            capUnsigned   <= 1'b0;
            capSize       <= SIZE_BYTE;
            tmoCnt        <= '0;
            flushPend     <= 1'b0;
            wb_valid      <= 1'b0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus4   <= '0;
            wb_write_reg  <= '0;
            wb_mem_to_reg <= '0;
            wb_reg_write  <= 1'b0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            wb_valid <= passFire | misFire | ((ackDone | tmoDone) & ~suppress);
            misalign <= misFire;
            bus_err  <= tmoDone & ~suppress;

            if (startReq) begin
                memReq      <= 1'b1;
                memWe       <= in_mem_write;
                memAddr     <= {in_alu_result[XLEN-1:LANE_W], LANE_W'(0)};
                memWdata    <= laneWdata;
                memBe       <= laneBe;
                capAlu      <= in_alu_result;
                capPc       <= in_pc_plus4;
                capWriteReg <= in_write_reg;
                capMemToReg <= in_mem_to_reg;
                capRegWrite <= in_reg_write;
                capRead     <= in_mem_read;
                capUnsigned <= in_unsigned;
                capSize     <= memSizeE'(in_size);
                tmoCnt      <= '0;
                flushPend   <= 1'b0;
            end

            if (state == REQ) begin
                if (ackDone || tmoDone) begin
                    memReq    <= 1'b0;
                    flushPend <= 1'b0;
                end else begin
                    tmoCnt <= tmoCnt + 1'b1;
                    if (flush) begin
                        flushPend <= 1'b1;
                    end
                end
            end

            // Writeback fields only change when a writeback is produced.
            if (passFire || misFire) begin
                wb_alu_result <= in_alu_result;
                wb_read_data  <= '0;
                wb_pc_plus4   <= in_pc_plus4;
                wb_write_reg  <= in_write_reg;
                wb_mem_to_reg <= in_mem_to_reg;
                wb_reg_write  <= passFire & in_reg_write;
            end else if ((ackDone || tmoDone) && !suppress) begin
                wb_alu_result <= capAlu;
                wb_read_data  <= (ackDone && capRead) ? laneLoad : '0;
                wb_pc_plus4   <= capPc;
                wb_write_reg  <= capWriteReg;
                wb_mem_to_reg <= capMemToReg;
                wb_reg_write  <= ackDone & capRegWrite;
            end
        end
    end

endmodule
